// File: rtl/post_neuron_update_ctrl.sv
// ---------------------------------------------------------------------------
// post_neuron_update_ctrl
//
// Read-modify-write controller that owns every port of the post-neuron state
// SRAM (N x 32, synchronous, 1-cycle read latency). Each SRAM word holds
// {C[31:16] unsigned spike count, V[15:0] signed membrane potential}.
//
// Synaptic events (address + signed weight) are integrated into V. A
// threshold crossing resets V, bumps C (saturating) and emits a spike.
// A TICK pulse requests a leak sweep that pulls every neuron's V toward 0
// by LEAK without overshooting.
//
// Ports
//   CK, RST_N                     clock, async active-low reset
//   EV_VALID/EV_READY/EV_ADDR/EV_W  synaptic event handshake
//   TICK                          one-cycle timestep pulse (sticky request)
//   BUSY                          FSM not idle or a sweep is pending
//   SPK_VALID/SPK_READY/SPK_ADDR  spike output handshake
//   SRAM_CS/WE/A/D, SRAM_Q        SRAM master port and read data
// ---------------------------------------------------------------------------
module post_neuron_update_ctrl #(
  parameter int                 ADDR_WIDTH = 8,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 N_NEURON   = 256,
  parameter int                 W_WIDTH    = 8,
  parameter logic signed [15:0] THRESH     = 16'sd1000,
  parameter logic        [15:0] LEAK       = 16'd4
) (
  input  logic                  CK,
  input  logic                  RST_N,
  input  logic                  EV_VALID,
  output logic                  EV_READY,
  input  logic [ADDR_WIDTH-1:0] EV_ADDR,
  input  logic [W_WIDTH-1:0]    EV_W,
  input  logic                  TICK,
  output logic                  BUSY,
  output logic                  SPK_VALID,
  input  logic                  SPK_READY,
  output logic [ADDR_WIDTH-1:0] SPK_ADDR,
  output logic                  SRAM_CS,
  output logic                  SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E_RD = 3'd1,
    E_WR = 3'd2,
    SPK  = 3'd3,
    L_RD = 3'd4,
    L_WR = 3'd5
  } state_t;

  localparam int WPAD = 17 - W_WIDTH;

  // Clamp a 17-bit signed intermediate into the 16-bit potential range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    if (x > 17'sd32767)       return 16'sh7fff;
    else if (x < -17'sd32768) return 16'sh8000;
    else                      return x[15:0];
  endfunction

  // Move V toward zero by LEAK, clamping at zero so the sign never flips.
  function automatic logic signed [15:0] leak_toward_zero(input logic signed [15:0] v);
    logic signed [16:0] t;
    logic signed [16:0] lk;
    lk = $signed({1'b0, LEAK});
    t  = $signed({v[15], v});
    if (v > 16'sd0) begin
      t = t - lk;
      return (t < 17'sd0) ? 16'sd0 : t[15:0];
    end else if (v < 16'sd0) begin
      t = t + lk;
      return (t > 17'sd0) ? 16'sd0 : t[15:0];
    end
    return v;
  endfunction

  // Spike count saturates at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hffff) ? c : c + 16'd1;
  endfunction

  state_t                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic                    ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [W_WIDTH-1:0]      w_q;
  logic                    lat_en;

  logic signed [15:0]      v_rd;
  logic        [15:0]      c_rd;
  logic signed [16:0]      w_ext;
  logic signed [16:0]      s_sum;
  logic signed [15:0]      s_sat;
  logic                    fire;

  // Datapath on the word returned by the read issued in the previous cycle.
  assign v_rd  = $signed(SRAM_Q[15:0]);
  assign c_rd  = SRAM_Q[31:16];
  assign w_ext = $signed({{WPAD{w_q[W_WIDTH-1]}}, w_q});
  assign s_sum = $signed({v_rd[15], v_rd}) + w_ext;
  assign s_sat = sat16(s_sum);
  assign fire  = (s_sat >= THRESH);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | TICK;
    cnt_d     = cnt_q;
    lat_en    = 1'b0;
    SRAM_CS   = 1'b0;
    SRAM_WE   = 1'b0;
    SRAM_A    = '0;
    SRAM_D    = '0;
    SPK_VALID = 1'b0;
    SPK_ADDR  = '0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          // Ticks seen while already pending fold into this one sweep.
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = L_RD;
        end else if (EV_VALID && ready_q) begin
          lat_en  = 1'b1;
          state_d = E_RD;
        end
      end
      E_RD: begin
        SRAM_CS = 1'b1;
        SRAM_A  = addr_q;
        state_d = E_WR;
      end
      E_WR: begin
        SRAM_CS = 1'b1;
        SRAM_WE = 1'b1;
        SRAM_A  = addr_q;
        if (fire) begin
          SRAM_D  = DATA_WIDTH'({sat_inc16(c_rd), 16'h0000});
          state_d = SPK;
        end else begin
          SRAM_D  = DATA_WIDTH'({c_rd, s_sat});
          state_d = IDLE;
        end
      end
      SPK: begin
        SPK_VALID = 1'b1;
        SPK_ADDR  = addr_q;
        if (SPK_READY) state_d = IDLE;
      end
      L_RD: begin
        SRAM_CS = 1'b1;
        SRAM_A  = cnt_q;
        state_d = L_WR;
      end
      L_WR: begin
        SRAM_CS = 1'b1;
        SRAM_WE = 1'b1;
        SRAM_A  = cnt_q;
        SRAM_D  = DATA_WIDTH'({c_rd, leak_toward_zero(v_rd)});
        if (cnt_q == ADDR_WIDTH'(N_NEURON - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = L_RD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so EV_READY is guaranteed low while reset is held.
    ready_d = (state_d == IDLE) && !pend_d;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  // Event operands; only observed in E_RD/E_WR/SPK, so no reset needed.
  always_ff @(posedge CK) begin
    if (lat_en) begin
      addr_q <= EV_ADDR;
      w_q    <= EV_W;
    end
  end

  assign EV_READY = ready_q;
  assign BUSY     = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_post_neuron_update_ctrl.sv
module tb_post_neuron_update_ctrl;
  localparam int NN  = 4;
  localparam int THR = 1000;
  localparam int LK  = 4;

  logic        CK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EV_VALID = 1'b0;
  logic        TICK = 1'b0;
  logic        SPK_READY = 1'b0;
  logic [7:0]  EV_ADDR = 8'd0;
  logic [7:0]  EV_W = 8'd0;
  logic        EV_READY, BUSY, SPK_VALID, SRAM_CS, SRAM_WE;
  logic [7:0]  SPK_ADDR, SRAM_A;
  logic [31:0] SRAM_D;
  logic [31:0] SRAM_Q = 32'd0;

  always #5 CK = ~CK;

  post_neuron_update_ctrl #(.N_NEURON(NN)) dut (
    .CK(CK), .RST_N(RST_N),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_ADDR(EV_ADDR), .EV_W(EV_W),
    .TICK(TICK), .BUSY(BUSY),
    .SPK_VALID(SPK_VALID), .SPK_READY(SPK_READY), .SPK_ADDR(SPK_ADDR),
    .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
    .SRAM_Q(SRAM_Q)
  );

  // SRAM model with a side preload port owned by the bench.
  logic [31:0] sram [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = 8'd0;
  logic [31:0] pl_d = 32'd0;
  always @(posedge CK) begin
    if (pl_en) sram[pl_a] <= pl_d;
    else if (SRAM_CS) begin
      if (SRAM_WE) sram[SRAM_A] <= SRAM_D;
      else         SRAM_Q <= sram[SRAM_A];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_spk[$];
  wr_t        mon_e;
  logic [7:0] mon_s;

  int ref_v[256];
  int ref_c[256];

  logic spk_rand  = 1'b0;
  logic spk_force = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the stored neuron state.
  task automatic push_wr(input int a);
    wr_t e;
    int c, v;
    c = ref_c[a];
    v = ref_v[a];
    e.a = a[7:0];
    e.d = {c[15:0], v[15:0]};
    exp_wr.push_back(e);
  endtask

  task automatic ref_event(input int a, input int w);
    int s;
    s = ref_v[a] + w;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (s >= THR) begin
      ref_v[a] = 0;
      if (ref_c[a] < 65535) ref_c[a] = ref_c[a] + 1;
      exp_spk.push_back(a[7:0]);
    end else begin
      ref_v[a] = s;
    end
    push_wr(a);
  endtask

  task automatic ref_sweep();
    for (int i = 0; i < NN; i++) begin
      if (ref_v[i] > 0)      ref_v[i] = (ref_v[i] > LK) ? ref_v[i] - LK : 0;
      else if (ref_v[i] < 0) ref_v[i] = (ref_v[i] < -LK) ? ref_v[i] + LK : 0;
      push_wr(i);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the queues.
  always @(negedge CK) begin
    if (RST_N) begin
      if (SRAM_CS && SRAM_WE) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected", SRAM_A, SRAM_D);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 64'(SRAM_A), 64'(mon_e.a));
          chk("wr_data", 64'(SRAM_D), 64'(mon_e.d));
        end
      end
      if (SPK_VALID && SPK_READY) begin
        if (exp_spk.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_spike: addr %0d, none expected", SPK_ADDR);
        end else begin
          mon_s = exp_spk.pop_front();
          chk("spk_addr", 64'(SPK_ADDR), 64'(mon_s));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CK); #2;
      SPK_READY = spk_rand ? 1'($urandom_range(0, 1)) : spk_force;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CK); #1;
  endtask

  task automatic preload(input int a, input int c, input int v);
    pl_en = 1'b1; pl_a = a[7:0]; pl_d = {c[15:0], v[15:0]};
    step();
    pl_en = 1'b0;
    ref_v[a] = v;
    ref_c[a] = c;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CK);
    while (BUSY && n < 3000) begin @(negedge CK); n++; end
    if (BUSY) chk("idle_timeout", 64'(BUSY), 64'd0);
    step();
  endtask

  task automatic send_event(input int a, input int w, output int acc);
    int n;
    n = 0;
    acc = 0;
    EV_ADDR = a[7:0]; EV_W = w[7:0]; EV_VALID = 1'b1;
    @(negedge CK);
    while (!EV_READY && n < 3000) begin @(negedge CK); n++; end
    if (!EV_READY) begin
      chk("accept_timeout", 64'(EV_READY), 64'd1);
      EV_VALID = 1'b0;
      return;
    end
    acc = cyc;
    step();
    EV_VALID = 1'b0;
    ref_event(a, w);
  endtask

  task automatic send_tick();
    int n;
    n = 0;
    @(negedge CK);
    while (BUSY && n < 3000) begin @(negedge CK); n++; end
    if (BUSY) chk("tick_wait_timeout", 64'(BUSY), 64'd0);
    TICK = 1'b1;
    step();
    TICK = 1'b0;
    ref_sweep();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ev_ready"}, 64'(EV_READY), 64'd0);
    chk({tag, "_busy"},     64'(BUSY),     64'd0);
    chk({tag, "_spk_valid"},64'(SPK_VALID),64'd0);
    chk({tag, "_spk_addr"}, 64'(SPK_ADDR), 64'd0);
    chk({tag, "_sram_cs"},  64'(SRAM_CS),  64'd0);
    chk({tag, "_sram_we"},  64'(SRAM_WE),  64'd0);
    chk({tag, "_sram_a"},   64'(SRAM_A),   64'd0);
    chk({tag, "_sram_d"},   64'(SRAM_D),   64'd0);
  endtask

  initial begin
    int acc, n, cs_n, rdy_bad, w, a;
    logic [31:0] want;

    #3;
    chk_all_zero("reset");
    repeat (2) step();
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++) preload(i, 0, 0);

    // Threshold crossing with spike latency measurement.
    spk_force = 1'b1;
    preload(5, 0, 990);
    send_event(5, 20, acc);
    n = 0;
    @(negedge CK);
    while (!SPK_VALID && n < 20) begin @(negedge CK); n++; end
    chk("spk_latency", 64'(cyc - acc), 64'd3);
    chk("spk_addr_direct", 64'(SPK_ADDR), 64'd5);
    @(negedge CK);
    chk("spk_one_cycle", 64'(SPK_VALID), 64'd0);
    wait_idle();

    // Positive and negative saturation, count saturation.
    preload(7, 0, 32760);
    send_event(7, 127, acc);
    wait_idle();
    preload(8, 0, -32700);
    send_event(8, -128, acc);
    wait_idle();
    preload(9, 65535, 999);
    send_event(9, 1, acc);
    wait_idle();

    // Leak sweep timing and results.
    preload(0, 0, 10);
    preload(1, 2, -3);
    preload(2, 0, 0);
    preload(3, 7, -2);
    send_tick();
    @(negedge CK);
    chk("sweep_busy", 64'(BUSY), 64'd1);
    cs_n = 0; rdy_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (SRAM_CS) cs_n++;
      else if (cs_n > 0) break;
      if (EV_READY) rdy_bad++;
      @(negedge CK);
    end
    chk("sweep_cycles", 64'(cs_n), 64'(2 * NN));
    chk("ev_ready_in_sweep", 64'(rdy_bad), 64'd0);
    wait_idle();

    // Spike back-pressure with ticks arriving during the stall.
    spk_force = 1'b0;
    preload(5, 1, 995);
    send_event(5, 10, acc);
    n = 0;
    @(negedge CK);
    while (!SPK_VALID && n < 20) begin @(negedge CK); n++; end
    for (int k = 0; k < 5; k++) begin
      step();
      TICK = (k == 1 || k == 3);
      @(negedge CK);
      chk("stall_valid", 64'(SPK_VALID), 64'd1);
      chk("stall_addr",  64'(SPK_ADDR),  64'd5);
      chk("stall_no_sram", 64'(SRAM_CS), 64'd0);
    end
    step();
    TICK = 1'b0;
    spk_force = 1'b1;
    ref_sweep();
    step();
    spk_force = 1'b0;
    @(negedge CK);
    chk("post_hs_busy", 64'(BUSY), 64'd1);
    @(negedge CK);
    chk("sweep_start_cs", 64'(SRAM_CS), 64'd1);
    chk("sweep_start_we", 64'(SRAM_WE), 64'd0);
    chk("sweep_start_a",  64'(SRAM_A),  64'd0);
    wait_idle();

    // Reset with an event in flight.
    spk_force = 1'b1;
    preload(10, 0, 500);
    EV_ADDR = 8'd10; EV_W = 8'd50; EV_VALID = 1'b1;
    n = 0;
    @(negedge CK);
    while (!EV_READY && n < 100) begin @(negedge CK); n++; end
    step();
    EV_VALID = 1'b0;
    chk("inflight_read", 64'(SRAM_CS), 64'd1);
    RST_N = 1'b0;
    #1;
    chk_all_zero("midop");
    step();
    step();
    RST_N = 1'b1;
    repeat (6) step();
    want = {16'd0, 16'd500};
    chk("reset_no_write", 64'(sram[10]), 64'(want));

    // Randomized traffic against the reference model.
    spk_rand = 1'b1;
    for (int i = 0; i < 16; i++)
      preload(i, (i % 5 == 0) ? 65535 : int'($urandom_range(0, 300)),
              int'($urandom_range(0, 2200)) - 1100);
    for (int it = 0; it < 160; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_tick();
      end else begin
        a = int'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) w = -int'($urandom_range(0, 128));
        else                           w = int'($urandom_range(0, 127));
        send_event(a, w, acc);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end
    wait_idle();
    repeat (4) step();
    chk("wr_queue_empty",  64'(exp_wr.size()),  64'd0);
    chk("spk_queue_empty", 64'(exp_spk.size()), 64'd0);
    for (int i = 0; i < 16; i++) begin
      want = {ref_c[i][15:0], ref_v[i][15:0]};
      chk("final_mem", 64'(sram[i]), 64'(want));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
